rotate_sched: RTL and testbench
===============================

Name: rotate_sched

Overview:
- Shares one W-bit left-rotate datapath between N requesters.
- Round-robin arbiter selects one valid request per cycle, rotates its operand, and holds the result in a single-entry output register tagged with the requester id.
- Valid/ready handshakes on both sides.
- Sits between per-lane issue logic and a common result bus.

Parameters:
- W, 32, operand/result width; power of two, >= 2.
- N, 4, number of requesters; >= 2.
- NW, $clog2(W)+1, rotate-amount width per requester (derived, not overridden).
- IW, (N>1 ? $clog2(N) : 1), requester-id width (derived).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_vld  in  N  request valid, one bit per requester.
- req_x  in  N*W  operands; requester i at [i*W +: W].
- req_n  in  N*NW  rotate amounts; requester i at [i*NW +: NW].
- req_rdy  out  N  one-hot (or zero) accept strobe.
- rsp_vld  out  1  result valid.
- rsp_y  out  W  rotated result.
- rsp_id  out  IW  index of the requester that produced rsp_y.
- rsp_rdy  in  1  downstream accepts result.
- rsp_cnt  out  16  count of completed responses; wraps.

Behaviour:
- Reset: rsp_vld=0, rsp_y=0, rsp_id=0, rsp_cnt=0, round-robin pointer ptr=0 (requester 0 highest priority). req_rdy=0 while rst is asserted.
- Reset mid-operation: any held result is discarded, with no response. Pointer and counter return to 0.
- Rotation is left rotate, y = x rotated left by (n mod W):
  - n=0 and n=W both give y=x.
  - n>W wraps modulo W, e.g. W=32, n=33 rotates by 1.
  - Bits shifted out of the MSB re-enter at the LSB.
- Accept condition, combinational: acc = ~rsp_vld | rsp_rdy. A full register draining this cycle can be refilled the same cycle, giving full throughput of 1 result/cycle.
- Arbitration, combinational:
  - Scan requesters ptr, ptr+1, ..., ptr+N-1 (mod N).
  - The first with req_vld=1 is the grant g.
  - req_rdy[g] = acc & any(req_vld). All other req_rdy bits are 0.
  - req_rdy does not depend on req_rdy of other requesters and has no path from req_x/req_n.
- Transfer on requester i: req_vld[i] & req_rdy[i]. On the next edge:
  - rsp_y <= rot(req_x[i], req_n[i])
  - rsp_id <= i
  - rsp_vld <= 1
  - ptr <= (i+1) mod N
- Pointer: unchanged when there is no transfer. Wraps N-1 -> 0.
- Output handshake:
  - If rsp_vld & rsp_rdy and there is no new transfer: rsp_vld <= 0; rsp_y/rsp_id hold their last value.
  - If rsp_vld & ~rsp_rdy: rsp_y, rsp_id and rsp_vld are held stable. No req_rdy is asserted (backpressure).
- Latency: 1 cycle from request transfer to rsp_vld.
- rsp_cnt increments by 1 on each rsp_vld & rsp_rdy cycle; 0xFFFF -> 0x0000.
- Requester obligation: once req_vld[i]=1, requester i holds req_vld[i], req_x and req_n stable until req_rdy[i]. A violation is a requester bug; the block makes no correction.
- Simultaneous events:
  - Drain and refill in the same cycle: the new result replaces the old one and rsp_vld stays 1.
  - All requesters valid every cycle: grants rotate 0,1,...,N-1,0,...
  - No requester waits more than N-1 grants.

Test Plan:
- Reset, then idle: rsp_vld=0, req_rdy=0000, rsp_cnt=0.
- Single rotation, W=32:
  - Requester 2: x=0x80000001, n=1, rsp_rdy=1 -> next cycle rsp_vld=1, rsp_y=0x00000003, rsp_id=2.
  - Same requester with n=32 -> rsp_y=0x80000001.
  - Same requester with n=36 -> rsp_y=0x00000018.
- All 4 requesters held valid, rsp_rdy=1 for 8 cycles:
  - Grant order 0,1,2,3,0,1,2,3, one response per cycle.
  - rsp_cnt=8 after the final accept.
- Backpressure:
  - rsp_rdy=0 for 3 cycles while requesters 1 and 3 are valid: rsp_y/rsp_id are stable and req_rdy=0000.
  - Raise rsp_rdy: requester 1's result drains, requester 3 is granted in the same cycle, and its result appears next cycle.
- Fairness after pointer move:
  - ptr=3 after granting requester 2; requesters 0 and 3 both valid -> requester 3 granted first, then requester 0.
- Asynchronous reset asserted mid-cycle while rsp_vld=1 and rsp_cnt=5:
  - rsp_vld, rsp_cnt and ptr clear immediately, without waiting for a clock edge.
  - After release, a request from requester 1 is granted ahead of requester 0 only if requester 0 is not valid.

Source files
------------

// File: rtl/rotate_sched.sv
// rotate_sched: one shared W-bit left-rotate datapath serving N requesters through
// a round-robin arbiter, with a single-entry tagged output register.
module rotate_sched #(
    parameter int W = 32,
    parameter int N = 4,
    localparam int NW = $clog2(W) + 1,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_vld,
    input  logic [N*W-1:0]  req_x,
    input  logic [N*NW-1:0] req_n,
    output logic [N-1:0]    req_rdy,
    output logic            rsp_vld,
    output logic [W-1:0]    rsp_y,
    output logic [IW-1:0]   rsp_id,
    input  logic            rsp_rdy,
    output logic [15:0]     rsp_cnt
);

    localparam int LW = $clog2(W);

    logic [IW-1:0]  ptr;
    logic           acc;
    logic           found;
    logic           xfer;
    logic [IW-1:0]  grant;
    logic [IW-1:0]  idx;
    logic [W-1:0]   sel_x;
    logic [NW-1:0]  sel_n;
    logic [LW-1:0]  amt;
    logic [2*W-1:0] dbl;
    logic [W-1:0]   rot_y;

    // The register can take a new result when empty or when it drains this cycle.
    assign acc = ~rsp_vld | rsp_rdy;

    // Scan from ptr+N-1 down to ptr so the requester closest to ptr is the last
    // (and therefore winning) assignment.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % N);
            if (req_vld[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        req_rdy = '0;
        if (found && acc && !rst) begin
            req_rdy[grant] = 1'b1;
        end
    end

    assign xfer = |req_rdy;

    assign sel_x = req_x[int'(grant) * W +: W];
    assign sel_n = req_n[int'(grant) * NW +: NW];

    // W is a power of two, so the modulo reduces to the low LW bits.
    assign amt   = LW'(sel_n % NW'(W));
    assign dbl   = {sel_x, sel_x} << amt;
    assign rot_y = dbl[2*W-1:W];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld <= 1'b0;
            rsp_y   <= '0;
            rsp_id  <= '0;
            ptr     <= '0;
        end else if (xfer) begin
            rsp_vld <= 1'b1;
            rsp_y   <= rot_y;
            rsp_id  <= grant;
            ptr     <= (grant == IW'(N - 1)) ? '0 : grant + 1'b1;
        end else if (rsp_vld && rsp_rdy) begin
            rsp_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_cnt <= '0;
        end else if (rsp_vld && rsp_rdy) begin
            rsp_cnt <= rsp_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rotate_sched.sv
// Scoreboard bench for rotate_sched: a reference model predicts grants and rotated
// results; a separate monitor checks each presented response against the queue.
module tb_rotate_sched;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int NW = $clog2(W) + 1;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_vld = '0;
    logic [N*W-1:0]  req_x = '0;
    logic [N*NW-1:0] req_n = '0;
    logic [N-1:0]    req_rdy;
    logic            rsp_vld;
    logic [W-1:0]    rsp_y;
    logic [IW-1:0]   rsp_id;
    logic            rsp_rdy = 1'b1;
    logic [15:0]     rsp_cnt;

    rotate_sched #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_x(req_x), .req_n(req_n), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_rdy(rsp_rdy),
        .rsp_cnt(rsp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [W-1:0] y;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [N-1:0] granted = '0;
    logic        m_vld = 1'b0;
    int          m_ptr = 0;
    int          m_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Bit j of x lands at position (j + n) mod W.
    function automatic logic [W-1:0] ref_rot(input logic [W-1:0] x, input int n);
        logic [W-1:0] y;
        int s;
        y = '0;
        s = n % W;
        for (int j = 0; j < W; j++) y[(j + s) % W] = x[j];
        return y;
    endfunction

    // Reference model: predicts acceptance and grant, pushes expected results.
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int best;
        int best_d;
        int d;
        if (rst) begin
            exp_q.delete();
            m_vld   = 1'b0;
            m_ptr   = 0;
            granted = '0;
            check("req_rdy_in_reset", req_rdy, '0);
        end else begin
            best   = -1;
            best_d = N;
            for (int i = 0; i < N; i++) begin
                d = (i - m_ptr + N) % N;
                if (req_vld[i] && d < best_d) begin
                    best   = i;
                    best_d = d;
                end
            end
            exp_rdy = '0;
            if ((!m_vld || rsp_rdy) && best >= 0) exp_rdy[best] = 1'b1;
            check("req_rdy", req_rdy, exp_rdy);
            check("rsp_vld", rsp_vld, m_vld);
            granted = exp_rdy;
            if (best >= 0 && exp_rdy != 0) begin
                exp_q.push_back('{id: best,
                                  y: ref_rot(req_x[best*W +: W], int'(req_n[best*NW +: NW]))});
                m_vld = 1'b1;
                m_ptr = (best + 1) % N;
            end else if (m_vld && rsp_rdy) begin
                m_vld = 1'b0;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queue head.
    always @(negedge clk) begin
        if (rst) begin
            m_cnt = 0;
            check("rsp_vld_in_reset", rsp_vld, 0);
            check("rsp_cnt_in_reset", rsp_cnt, 0);
        end else begin
            check("rsp_cnt", rsp_cnt, 64'(m_cnt[15:0]));
            if (rsp_vld) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    check("rsp_id", rsp_id, exp_q[0].id);
                    check("rsp_y", rsp_y, exp_q[0].y);
                    if (rsp_rdy) begin
                        void'(exp_q.pop_front());
                        m_cnt++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_vld = req_vld & ~granted;
    endtask

    task automatic drive(input int i, input logic [W-1:0] x, input int n);
        req_vld[i]          = 1'b1;
        req_x[i*W +: W]     = x;
        req_n[i*NW +: NW]   = NW'(n);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (req_vld != '0 && t < 50) begin
            tick();
            t++;
        end
        check("requests_drained", req_vld, '0);
    endtask

    task automatic cycles(input int k);
        for (int c = 0; c < k; c++) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle.
        cycles(3);
        rst = 1'b0;
        check("rsp_y_after_reset", rsp_y, '0);
        check("rsp_id_after_reset", rsp_id, '0);
        cycles(2);

        // Single rotations on requester 2.
        drive(2, 32'h8000_0001, 1);
        wait_idle();
        cycles(1);
        drive(2, 32'h8000_0001, 32);
        wait_idle();
        cycles(1);
        drive(2, 32'h8000_0001, 36);
        wait_idle();
        cycles(2);

        // All requesters held valid for 8 cycles at full throughput.
        for (int i = 0; i < N; i++) drive(i, $urandom, $urandom_range(0, (1 << NW) - 1));
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c < 7) begin
                for (int i = 0; i < N; i++)
                    if (granted[i]) drive(i, $urandom, $urandom_range(0, (1 << NW) - 1));
            end
        end
        wait_idle();
        cycles(2);

        // Backpressure with requesters 1 and 3.
        rsp_rdy = 1'b0;
        drive(1, 32'hDEAD_BEEF, 5);
        drive(3, 32'h0123_4567, 63);
        cycles(4);
        rsp_rdy = 1'b1;
        wait_idle();
        cycles(2);

        // Fairness after the pointer moves past requester 2.
        drive(2, 32'hF000_000F, 4);
        wait_idle();
        drive(0, 32'h0000_00FF, 8);
        drive(3, 32'hFF00_0000, 16);
        wait_idle();
        cycles(2);

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            rsp_rdy = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++)
                if (!req_vld[i] && $urandom_range(0, 1) == 1)
                    drive(i, $urandom, $urandom_range(0, (1 << NW) - 1));
            tick();
        end
        rsp_rdy = 1'b1;
        wait_idle();
        cycles(3);

        // Reach rsp_cnt=5 with a held result, then reset asynchronously mid-cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 5; r++) begin
            drive(1, $urandom, $urandom_range(0, (1 << NW) - 1));
            wait_idle();
        end
        cycles(2);
        rsp_rdy = 1'b0;
        drive(1, 32'hA5A5_0F0F, 7);
        wait_idle();
        cycles(2);
        check("cnt_before_async_reset", rsp_cnt, 5);
        check("vld_before_async_reset", rsp_vld, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rsp_vld", rsp_vld, 0);
        check("async_rst_rsp_cnt", rsp_cnt, 0);
        check("async_rst_req_rdy", req_rdy, '0);
        cycles(2);
        rst = 1'b0;
        rsp_rdy = 1'b1;
        drive(0, 32'h1111_2222, 3);
        drive(1, 32'h3333_4444, 9);
        wait_idle();
        drive(1, 32'h5555_6666, 31);
        wait_idle();

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
        check("scoreboard_empty", exp_q.size(), 0);
        cycles(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
